// File: rtl/blink_sequencer.sv
// blink_sequencer: divided-clock pattern player for LEDs / slow IO.
// A prescaler turns clk into ticks while playing. A small step table
// (level + duration in ticks) is written through cfg_* while idle, then
// played out on `out` after `start`.
// Optional feature macro: BLINK_SEQ_LOOP_EN. When it is defined, a high `loop`
// at the ending tick restarts the table from entry 0 without a done pulse.
// When it is not defined, `loop` is ignored.
module blink_sequencer #(
  parameter int COUNT_WIDTH = 24,
  parameter int PRESCALE    = 6000000-1,
  parameter int ADDR_WIDTH  = 2,
  parameter int DUR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DUR_WIDTH:0]    cfg_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  output logic                  out,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] step
);
  localparam int STEPS = 2**ADDR_WIDTH;
  localparam logic [COUNT_WIDTH:0]  PRESC_MAX = (COUNT_WIDTH+1)'(PRESCALE);
  localparam logic [ADDR_WIDTH-1:0] LAST_STEP = ADDR_WIDTH'(STEPS-1);
  localparam logic [DUR_WIDTH-1:0]  DUR_ONE   = DUR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  out_q, out_d;
  logic [ADDR_WIDTH-1:0] step_q, step_d;
  logic [DUR_WIDTH-1:0]  rem_q, rem_d;
  logic [COUNT_WIDTH:0]  presc_q, presc_d;
  logic [DUR_WIDTH:0]    table_q [STEPS];

  logic                  tick;
  logic                  seq_end;
  logic [ADDR_WIDTH-1:0] next_idx;
  logic [DUR_WIDTH:0]    entry0;
  logic [DUR_WIDTH:0]    next_entry;

  assign tick       = (presc_q == PRESC_MAX);
  assign next_idx   = step_q + 1'b1;
  assign entry0     = table_q[0];
  assign next_entry = table_q[next_idx];

`ifndef BLINK_SEQ_LOOP_EN
  // Repeat requests have no effect in this build.
  logic unused_loop;
  assign unused_loop = loop;
`endif

  // Step table: writable only outside RUN so a playing pattern never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
    end else if (cfg_we && (state_q != S_RUN)) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= 1'b0;
      step_q  <= '0;
      rem_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
    end
  end

  // Next-state logic: start/stop handling, tick counting, step advance and end of sequence.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    step_d  = step_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    seq_end = 1'b0;
    case (state_q)
      S_RUN: begin
        if (stop) begin
          // An abort wins over a tick in the same cycle.
          state_d = S_IDLE;
          out_d   = 1'b0;
          step_d  = '0;
          rem_d   = '0;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (rem_q > DUR_ONE) begin
            rem_d = rem_q - DUR_ONE;
          end else if ((step_q == LAST_STEP) || (next_entry[DUR_WIDTH-1:0] == '0)) begin
            seq_end = 1'b1;
          end else begin
            // Load the next step on the same edge, so the pattern has no gap cycle.
            step_d = next_idx;
            out_d  = next_entry[DUR_WIDTH];
            rem_d  = next_entry[DUR_WIDTH-1:0];
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (seq_end) begin
          state_d = S_DONE;
          out_d   = 1'b0;
          step_d  = '0;
`ifdef BLINK_SEQ_LOOP_EN
          // Restart from entry 0 without leaving RUN. An empty entry 0 still ends normally.
          if (loop && (entry0[DUR_WIDTH-1:0] != '0)) begin
            state_d = S_RUN;
            out_d   = entry0[DUR_WIDTH];
            rem_d   = entry0[DUR_WIDTH-1:0];
          end
`endif
        end
      end
      default: begin
        // S_IDLE and S_DONE: DONE lasts one cycle and start is accepted in either state.
        state_d = S_IDLE;
        presc_d = '0;
        if (start) begin
          step_d = '0;
          if (entry0[DUR_WIDTH-1:0] == '0) begin
            state_d = S_DONE;
            out_d   = 1'b0;
          end else begin
            state_d = S_RUN;
            out_d   = entry0[DUR_WIDTH];
            rem_d   = entry0[DUR_WIDTH-1:0];
          end
        end
      end
    endcase
  end

  assign out  = out_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign step = step_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer with PRESCALE=3 (one tick every 4 clk).
// Each scenario pushes the expected per-cycle {out,busy,done,step} trace to a
// queue when it drives start. It then pops and compares one entry per cycle.
module tb_blink_sequencer;
  logic       clk, rst, cfg_we, start, stop, loop;
  logic [1:0] cfg_addr;
  logic [8:0] cfg_data;
  logic       out_w, busy_w, done_w;
  logic [1:0] step_w;

  typedef struct packed {
    logic       o;
    logic       b;
    logic       d;
    logic [1:0] s;
  } obs_t;

  obs_t exp_q[$];
  obs_t exp_o, got;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;

  blink_sequencer #(.COUNT_WIDTH(24), .PRESCALE(3), .ADDR_WIDTH(2), .DUR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .loop(loop),
    .out(out_w), .busy(busy_w), .done(done_w), .step(step_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void push(logic o, logic b, logic d, logic [1:0] s, int cnt);
    obs_t e;
    e = {o, b, d, s};
    for (int k = 0; k < cnt; k++) exp_q.push_back(e);
  endfunction

  // Expected trace for the case-1 table {1,2},{0,3},{1,1},{0,0}.
  function automatic void push_case1();
    push(1'b1, 1'b1, 1'b0, 2'd0, 8);
    push(1'b0, 1'b1, 1'b0, 2'd1, 12);
    push(1'b1, 1'b1, 1'b0, 2'd2, 4);
    push(1'b0, 1'b0, 1'b1, 2'd0, 1);
    push(1'b0, 1'b0, 1'b0, 2'd0, 2);
  endfunction

  task automatic write_entry(input logic [1:0] a, input logic [8:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load_case1();
    write_entry(2'd0, 9'h102);
    write_entry(2'd1, 9'h003);
    write_entry(2'd2, 9'h101);
    write_entry(2'd3, 9'h000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    got = {out_w, busy_w, done_w, step_w};
    n_tests++;
    if (got !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got obds=%b want %b", got, 5'b0);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_empty_table();
    pulse_start();
    push(1'b0, 1'b0, 1'b1, 2'd0, 1);
    push(1'b0, 1'b0, 1'b0, 2'd0, 3);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL empty[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
    end
  endtask

  task automatic test_pattern();
    load_case1();
    pulse_start();
    push_case1();
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL pattern[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
    end
  endtask

  task automatic test_stop();
    pulse_start();
    push(1'b1, 1'b1, 1'b0, 2'd0, 8);
    push(1'b0, 1'b1, 1'b0, 2'd1, 5);
    push(1'b0, 1'b0, 1'b0, 2'd0, 4);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == 12) stop = 1'b1;
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL stop[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
      stop = 1'b0;
    end
  endtask

  task automatic test_frozen_table();
    pulse_start();
    push_case1();
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == 3) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 9'h009; start = 1'b1;
      end
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL frozen[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
      cfg_we = 1'b0; start = 1'b0;
    end
  endtask

  task automatic test_write_with_start();
    // Same-cycle write and start: the run uses the old entry 0 ({1,2}).
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 9'h101; start = 1'b1;
    cyc();
    cfg_we = 1'b0; start = 1'b0;
    push_case1();
    // The next run sees the new entry 0 ({1,1}).
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL wr_start_old[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
    end
    pulse_start();
    push(1'b1, 1'b1, 1'b0, 2'd0, 4);
    push(1'b0, 1'b1, 1'b0, 2'd1, 12);
    push(1'b1, 1'b1, 1'b0, 2'd2, 4);
    push(1'b0, 1'b0, 1'b1, 2'd0, 1);
    push(1'b0, 1'b0, 1'b0, 2'd0, 1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL wr_start_new[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
    end
  endtask

  task automatic test_all_ones_and_reset();
    for (int a = 0; a < 4; a++) write_entry(2'(a), 9'h101);
    pulse_start();
    push(1'b1, 1'b1, 1'b0, 2'd0, 4);
    push(1'b1, 1'b1, 1'b0, 2'd1, 4);
    push(1'b1, 1'b1, 1'b0, 2'd2, 4);
    push(1'b1, 1'b1, 1'b0, 2'd3, 4);
    push(1'b0, 1'b0, 1'b1, 2'd0, 1);
    push(1'b0, 1'b0, 1'b0, 2'd0, 1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL all_ones[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
    end
    // Assert reset mid-run: the outputs clear without waiting for a clock edge.
    pulse_start();
    repeat (5) cyc();
    rst = 1'b1;
    #1;
    got = {out_w, busy_w, done_w, step_w};
    n_tests++;
    if (got !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got obds=%b want %b", got, 5'b0);
    end
    cyc();
    rst = 1'b0;
    cyc();
    // The reset cleared the table, so start ends at once.
    pulse_start();
    push(1'b0, 1'b0, 1'b1, 2'd0, 1);
    push(1'b0, 1'b0, 1'b0, 2'd0, 1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL cleared_table[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
    end
  endtask

  task automatic test_loop();
    write_entry(2'd0, 9'h101);
    write_entry(2'd1, 9'h001);
    write_entry(2'd2, 9'h101);
    write_entry(2'd3, 9'h001);
    loop = 1'b1;
    pulse_start();
`ifdef BLINK_SEQ_LOOP_EN
    for (int r = 0; r < 2; r++) begin
      push(1'b1, 1'b1, 1'b0, 2'd0, 4);
      push(1'b0, 1'b1, 1'b0, 2'd1, 4);
      push(1'b1, 1'b1, 1'b0, 2'd2, 4);
      push(1'b0, 1'b1, 1'b0, 2'd3, 4);
    end
`else
    push(1'b1, 1'b1, 1'b0, 2'd0, 4);
    push(1'b0, 1'b1, 1'b0, 2'd1, 4);
    push(1'b1, 1'b1, 1'b0, 2'd2, 4);
    push(1'b0, 1'b1, 1'b0, 2'd3, 4);
`endif
    push(1'b0, 1'b0, 1'b1, 2'd0, 1);
    push(1'b0, 1'b0, 1'b0, 2'd0, 2);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == 20) loop = 1'b0;
      exp_o = exp_q.pop_front();
      got = {out_w, busy_w, done_w, step_w};
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL loop[%0d]: got obds=%b want %b", i, got, exp_o);
      end
      cyc();
    end
    loop = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_empty_table();
    test_pattern();
    test_stop();
    test_frozen_table();
    test_write_with_start();
    test_all_ones_and_reset();
    test_loop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
